// File: rtl/mem_port_arbiter.sv
// Shares one single-ported word memory between the instruction-fetch
// and data load/store ports: data-priority arbitration with a bound on
// how long a pending fetch can starve. Each access runs through a small
// FSM, and read data comes back registered with a one-cycle ack pulse.
// Ports: mem_clk/nreset; i_* fetch port (req/addr in; rdata/ack/err out);
// d_* data port (req/we/addr/wdata in; rdata/ack/err out);
// m_* memory side (en/we/addr/wdata out; rdata in); busy out.
module mem_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic              mem_clk,
  input  logic              nreset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              d_err,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t            state_q, state_d;
  logic              go_q, go_d;
  logic              own_q, own_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              i_err_q, i_err_d;
  logic              d_err_q, d_err_d;
  logic [CW-1:0]     starve_cnt_q, starve_cnt_d;

  logic              arb_ok;
  logic              starved;
  logic              pick_d;
  logic              mis;

  // Grants are taken only in a quiet IDLE cycle: no grant pending
  // and no ack on either port, so a requester that holds req across
  // its own ack is never double-granted.
  assign arb_ok  = (state_q == IDLE) & ~go_q & ~i_ack_q & ~d_ack_q;
  assign starved = starve_cnt_q == CW'(STARVE_MAX);
  assign pick_d  = d_req & ~(i_req & starved);
  assign mis     = pick_d ? (d_addr[1:0] != 2'b00)
                          : (i_addr[1:0] != 2'b00);

  always_comb begin
    state_d      = state_q;
    go_d         = 1'b0;
    own_d        = own_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    i_ack_d      = 1'b0;
    d_ack_d      = 1'b0;
    i_err_d      = 1'b0;
    d_err_d      = 1'b0;
    starve_cnt_d = starve_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (!i_req) starve_cnt_d = '0;
        if (go_q) begin
          state_d = ACCESS;
        end else if (arb_ok && (i_req || d_req)) begin
          own_d  = pick_d;
          addr_d = pick_d ? d_addr : i_addr;
          we_d   = pick_d & d_we;
          if (pick_d) wdata_d = d_wdata;
          if (!pick_d) begin
            starve_cnt_d = '0;
          end else if (i_req && !starved) begin
            starve_cnt_d = starve_cnt_q + CW'(1);
          end
          // Misaligned: answer with ack+err next cycle, skip memory.
          if (mis) begin
            d_ack_d = pick_d;
            d_err_d = pick_d;
            i_ack_d = ~pick_d;
            i_err_d = ~pick_d;
          end else begin
            go_d = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d = IDLE;
          d_ack_d = 1'b1;
        end else begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
        if (own_q) begin
          d_rdata_d = m_rdata;
          d_ack_d   = 1'b1;
        end else begin
          i_rdata_d = m_rdata;
          i_ack_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge mem_clk or negedge nreset) begin
    if (!nreset) begin
      state_q      <= IDLE;
      go_q         <= 1'b0;
      own_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      i_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      i_err_q      <= 1'b0;
      d_err_q      <= 1'b0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      go_q         <= go_d;
      own_q        <= own_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      i_ack_q      <= i_ack_d;
      d_ack_q      <= d_ack_d;
      i_err_q      <= i_err_d;
      d_err_q      <= d_err_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign m_en    = state_q == ACCESS;
  assign m_we    = m_en & we_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign i_ack   = i_ack_q;
  assign d_ack   = d_ack_q;
  assign i_err   = i_err_q;
  assign d_err   = d_err_q;
  assign busy    = state_q != IDLE;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small word memory model.
// Ports: none (top-level bench).
module tb_mem_port_arbiter;

  logic        mem_clk;
  logic        nreset;
  logic        i_req;
  logic [15:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        i_err;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        d_err;
  logic        m_en;
  logic        m_we;
  logic [15:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        busy;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [0:63];

  mem_port_arbiter dut (
    .mem_clk (mem_clk),
    .nreset  (nreset),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_rdata (i_rdata),
    .i_ack   (i_ack),
    .i_err   (i_err),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_rdata (d_rdata),
    .d_ack   (d_ack),
    .d_err   (d_err),
    .m_en    (m_en),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata),
    .busy    (busy)
  );

  initial mem_clk = 1'b0;
  always #5 mem_clk = ~mem_clk;

  always @(posedge mem_clk) begin
    if (m_en) begin
      if (m_we) mem[m_addr[7:2]] <= m_wdata;
      else m_rdata <= mem[m_addr[7:2]];
    end
  end

  task automatic tick();
    @(posedge mem_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [15:0] seq_a [0:4];
  logic [31:0] seq_c [0:4];
  int          n;
  logic        got;

  initial begin
    nreset  = 1'b0;
    i_req   = 1'b0;
    i_addr  = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    mem[0]  <= 32'hA5A5_0000;
    mem[4]  <= 32'hC800_0000;
    mem[16] <= 32'h1234_5678;
    #12;
    chk("rst_i_ack", 32'(i_ack), 0);
    chk("rst_d_ack", 32'(d_ack), 0);
    chk("rst_m_en", 32'(m_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_m_addr", 32'(m_addr), 0);
    tick();
    nreset = 1'b1;
    tick();

    // instruction read, 3-cycle latency
    i_req = 1'b1; i_addr = 16'h0010;
    tick();
    chk("ir_g_m_en", 32'(m_en), 0);
    tick();
    chk("ir_m_en", 32'(m_en), 1);
    chk("ir_m_we", 32'(m_we), 0);
    chk("ir_m_addr", 32'(m_addr), 32'h10);
    chk("ir_busy", 32'(busy), 1);
    tick();
    chk("ir_resp_ack", 32'(i_ack), 0);
    tick();
    chk("ir_ack", 32'(i_ack), 1);
    chk("ir_err", 32'(i_err), 0);
    chk("ir_rdata", i_rdata, 32'hC800_0000);
    i_req = 1'b0;
    tick();
    chk("ir_ack_pulse", 32'(i_ack), 0);
    chk("ir_busy_after", 32'(busy), 0);

    // data write, 2-cycle latency
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0020;
    d_wdata = 32'hDEAD_BEEF;
    tick();
    d_wdata = 32'h0;
    tick();
    chk("dw_m_en", 32'(m_en), 1);
    chk("dw_m_we", 32'(m_we), 1);
    chk("dw_m_wdata", m_wdata, 32'hDEAD_BEEF);
    chk("dw_m_addr", 32'(m_addr), 32'h20);
    tick();
    chk("dw_ack", 32'(d_ack), 1);
    chk("dw_err", 32'(d_err), 0);
    chk("dw_m_we_off", 32'(m_we), 0);
    d_req = 1'b0;
    tick();
    chk("dw_ack_pulse", 32'(d_ack), 0);
    chk("dw_mem", mem[8], 32'hDEAD_BEEF);

    // data read back, 3-cycle latency
    d_req = 1'b1; d_we = 1'b0;
    tick();
    tick();
    chk("dr_m_we", 32'(m_we), 0);
    tick();
    chk("dr_resp_ack", 32'(d_ack), 0);
    tick();
    chk("dr_ack", 32'(d_ack), 1);
    chk("dr_rdata", d_rdata, 32'hDEAD_BEEF);
    d_req = 1'b0;
    tick();

    // contention: data served first, then instruction
    i_req = 1'b1; i_addr = 16'h0000;
    d_req = 1'b1; d_addr = 16'h0040; d_we = 1'b0;
    tick();
    tick();
    chk("ct_d_m_addr", 32'(m_addr), 32'h40);
    chk("ct_d_m_en", 32'(m_en), 1);
    tick();
    tick();
    chk("ct_d_ack", 32'(d_ack), 1);
    chk("ct_no_i_ack", 32'(i_ack), 0);
    chk("ct_d_rdata", d_rdata, 32'h1234_5678);
    d_req = 1'b0;
    tick();
    chk("ct_gap_m_en", 32'(m_en), 0);
    tick();
    tick();
    chk("ct_i_m_en", 32'(m_en), 1);
    chk("ct_i_m_addr", 32'(m_addr), 32'h0);
    tick();
    tick();
    chk("ct_i_ack", 32'(i_ack), 1);
    chk("ct_no_d_ack", 32'(d_ack), 0);
    chk("ct_i_rdata", i_rdata, 32'hA5A5_0000);
    i_req = 1'b0;
    tick();

    // starvation: three data grants, then instruction, then data
    i_req = 1'b1; i_addr = 16'h0010;
    d_req = 1'b1; d_addr = 16'h0040; d_we = 1'b0;
    n = 0;
    for (int c = 0; c < 80 && n < 5; c++) begin
      tick();
      if (m_en) begin
        seq_a[n] = m_addr;
        seq_c[n] = 32'(dut.starve_cnt_q);
        n++;
      end
      if (i_ack) i_req = 1'b0;
      chk("st_ack_overlap", 32'(i_ack & d_ack), 0);
    end
    chk("st_count", n, 5);
    if (n == 5) begin
      chk("st_g0", 32'(seq_a[0]), 32'h40);
      chk("st_g1", 32'(seq_a[1]), 32'h40);
      chk("st_g2", 32'(seq_a[2]), 32'h40);
      chk("st_g3", 32'(seq_a[3]), 32'h10);
      chk("st_g4", 32'(seq_a[4]), 32'h40);
      chk("st_c2", seq_c[2], 3);
      chk("st_c3", seq_c[3], 0);
    end
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      tick();
      if (d_ack) got = 1'b1;
    end
    chk("st_last_ack", 32'(got), 1);
    d_req = 1'b0;
    tick();

    // misaligned data and instruction
    d_req = 1'b1; d_addr = 16'h0022;
    tick();
    chk("md_ack", 32'(d_ack), 1);
    chk("md_err", 32'(d_err), 1);
    chk("md_m_en", 32'(m_en), 0);
    chk("md_rdata", d_rdata, 32'h1234_5678);
    d_req = 1'b0;
    tick();
    chk("md_ack_pulse", 32'(d_ack | m_en), 0);
    i_req = 1'b1; i_addr = 16'h0003;
    tick();
    chk("mi_ack", 32'(i_ack), 1);
    chk("mi_err", 32'(i_err), 1);
    chk("mi_m_en", 32'(m_en), 0);
    chk("mi_rdata", i_rdata, 32'hC800_0000);
    i_req = 1'b0;
    tick();
    chk("mi_ack_pulse", 32'(i_ack | m_en), 0);

    // reset in the middle of an access
    i_req = 1'b1; i_addr = 16'h0010;
    tick();
    tick();
    chk("ra_m_en", 32'(m_en), 1);
    #1;
    nreset = 1'b0;
    #1;
    chk("ra_m_en_drop", 32'(m_en), 0);
    chk("ra_busy_drop", 32'(busy), 0);
    i_req = 1'b0;
    tick();
    tick();
    nreset = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (i_ack) got = 1'b1;
    end
    chk("ra_no_ack", 32'(got), 0);
    chk("ra_busy", 32'(busy), 0);
    i_req = 1'b1;
    tick();
    tick();
    tick();
    tick();
    chk("ra_new_ack", 32'(i_ack), 1);
    chk("ra_new_rdata", i_rdata, 32'hC800_0000);
    i_req = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, 32-bit-wide synchronous memory between the CPU instruction-fetch port and the CPU data load/store port.
- Sits between the CPU core and the unified memory array on mem_clk.
- Arbitration is data-priority, with a starvation bound that protects instruction fetch.
- Sequences each access through a small state machine and returns registered read data with a one-cycle acknowledge pulse.

Parameters:
- ADDR_W, 16, byte-address width of both ports and the memory.
- DATA_W, 32, data width; the access unit is one aligned word.
- STARVE_MAX, 3, number of consecutive data grants allowed while i_req is pending before instruction fetch is forced to win.

Ports:
- mem_clk  in  1  memory-domain clock; all state updates on the rising edge.
- nreset  in  1  reset, asynchronous, active-low.
- i_req  in  1  instruction fetch request; level; held until i_ack.
- i_addr  in  ADDR_W  instruction fetch byte address.
- i_rdata  out  DATA_W  fetched word; valid while i_ack=1, held otherwise.
- i_ack  out  1  one-cycle completion pulse.
- i_err  out  1  pulses with i_ack when i_addr is misaligned.
- d_req  in  1  data request; level; held until d_ack.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  DATA_W  write data.
- d_rdata  out  DATA_W  load word; valid while d_ack=1.
- d_ack  out  1  one-cycle completion pulse.
- d_err  out  1  pulses with d_ack when d_addr is misaligned.
- m_en  out  1  memory access enable.
- m_we  out  1  memory write enable; qualified by m_en.
- m_addr  out  ADDR_W  memory address.
- m_wdata  out  DATA_W  memory write data.
- m_rdata  in  DATA_W  memory read data; valid the cycle after m_en=1 with m_we=0.
- busy  out  1  1 whenever state != IDLE.

Behaviour:
- Reset (async, nreset=0):
  - state=IDLE, starve_cnt=0.
  - All outputs 0, including i_rdata and d_rdata.
  - m_en drops immediately; any in-flight access is dropped and gets no ack.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - An eligible requester has req=1 and its ack is not currently high. A requester whose ack is high this cycle is ignored, so there is no double grant.
  - If none is eligible: stay in IDLE.
  - Winner selection: data wins, unless i_req is eligible and starve_cnt==STARVE_MAX, in which case instruction wins.
  - On grant: latch addr, we (instruction port always read) and wdata into m_addr/m_we/m_wdata, and record the owner.
  - Misaligned winner (addr[1:0]!=0): no memory access; the next cycle pulses ack+err for that port; rdata is unchanged; state stays IDLE.
  - Otherwise, next state is ACCESS.
- ACCESS:
  - m_en=1 for exactly one cycle.
  - Write: next state is IDLE, with d_ack=1 in that IDLE cycle. Write latency is 2 cycles from grant edge to ack.
  - Read: next state is RESP.
- RESP:
  - m_rdata is registered into the owner's rdata.
  - The owner's ack is high in the following IDLE cycle. Read latency is 3 cycles: request sampled at edge N, ack and data visible after edge N+3.
  - Next state is IDLE.
- m_addr/m_we/m_wdata hold their last values outside ACCESS. m_we=0 whenever m_en=0.
- Starvation counter:
  - Increments on each data grant while i_req=1, saturating at STARVE_MAX.
  - Clears on any instruction grant, or whenever i_req=0 in IDLE.
- Misaligned grants count as grants for the counter.
- Simultaneous i_req and d_req in IDLE: exactly one grant. The loser stays pending and is re-evaluated in the next IDLE cycle.
- Request fields may change after the grant; the arbiter uses only the latched copies.
- Dropping req before ack is illegal. The arbiter completes the transaction regardless.
- Acks are never high for both ports in the same cycle.

Test Plan:
- Instruction read: memory word at 0x0010 = 0xC8000000; i_req=1, i_addr=0x0010 sampled at edge N → m_en=1, m_we=0, m_addr=0x0010 after edge N+1; i_ack=1, i_rdata=0xC8000000 after edge N+3; single-cycle pulse; busy low after.
- Data write then read: d_we=1, d_addr=0x0020, d_wdata=0xDEADBEEF → m_we pulse with that data, d_ack after 2 cycles. Then a read of 0x0020 → d_rdata=0xDEADBEEF, d_ack after 3 cycles.
- Contention: i_req (0x0000) and d_req read (0x0040) rise in the same cycle → data served first. Instruction is granted in the first IDLE after d_ack and acks 3 cycles later. Acks never overlap.
- Starvation: STARVE_MAX=3, d_req held high continuously, i_req held high → exactly 3 data grants, then the instruction grant, then data resumes. starve_cnt=0 after the instruction grant.
- Misalignment: d_req with d_addr=0x0022 → d_ack=1 and d_err=1 on the next cycle; m_en never asserted; d_rdata unchanged. i_addr=0x0003 → i_ack=1 and i_err=1 likewise.
- Reset mid-access: assert nreset=0 while in ACCESS → m_en=0 immediately; no ack ever. After release: busy=0; a new i_req completes normally with 3-cycle latency.
